pipe_stage_skid_reg: RTL and testbench

- Parametrised successor of the fixed-field stage-boundary register, for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries an opaque data payload plus control bits (RegWrite, MemRead, output-select, …) with a valid/ready handshake.
- Adds synchronous flush and an optional 2-entry skid buffer, so backpressure from a downstream stall never produces a combinational path from out_ready to in_ready.
- Bubbles always present all-zero control bits, so a stalled or flushed slot can never write the register file.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/pipe_stage_skid_reg.sv | 110 +++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage-boundary registers.
package pipe_pkg;

  // State encoding of a stage register; the count of held entries follows from it.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  typedef enum logic [1:0] {
    StEmpty = ST_EMPTY,
    StFull  = ST_FULL,
    StSkid  = ST_SKID
  } state_e;

  // Default datapath widths.
  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  // Control bits carried across each stage boundary.
  // IF/ID carries only a predicted-taken flag.
  localparam int unsigned IF_ID_CTRL_W  = 1;
  // ID/EX: RegWrite, MemRead, MemWrite, ALU-src, 2-bit ALU op, 2-bit output-select.
  localparam int unsigned ID_EX_CTRL_W  = 8;
  // EX/MEM: RegWrite, MemRead, MemWrite, 2-bit output-select.
  localparam int unsigned EX_MEM_CTRL_W = 5;
  // MEM/WB: RegWrite, MemRead, 2-bit output-select.
  localparam int unsigned MEM_WB_CTRL_W = 4;

  // Number of beats held in a given state; illegal encodings report empty.
  function automatic logic [1:0] state_occupancy(input state_e st);
    logic [1:0] occ;
    occ = 2'd0;
    case (st)
      StEmpty: occ = 2'd0;
      StFull:  occ = 2'd1;
      StSkid:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage-boundary register with valid/ready handshake, synchronous flush,
// bubble masking of control bits and an optional 2-entry skid buffer.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = XLEN,
  parameter int unsigned CTRL_W  = MEM_WB_CTRL_W,
  parameter int unsigned SKID_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  state_e              state_q;
  logic [DATA_W-1:0]   main_data_q;
  logic [CTRL_W-1:0]   main_ctrl_q;
  logic [DATA_W-1:0]   skid_data_q;
  logic [CTRL_W-1:0]   skid_ctrl_q;
  logic                in_ready_q;
  logic                take;

  // Handshake decode: with the skid buffer in_ready is a flop, so out_ready never
  // reaches in_ready combinationally; without it the register frees up as it drains.
  always_comb begin
    out_valid = (state_q != StEmpty);
    in_ready  = (SKID_EN != 0) ? in_ready_q : (!out_valid || out_ready);
    take      = in_valid && in_ready;
    occupancy = state_occupancy(state_q);
  end

  // Stage FSM and both storage banks; flush outranks every handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      // Held payloads stay put (out_data does not toggle); the state alone
      // turns them into bubbles.
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          in_ready_q <= 1'b1;
          if (take) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
            state_q     <= StFull;
          end
        end
        StFull: begin
          if (take) begin
            if (out_ready) begin
              // Head leaves while the next beat lands: full throughput.
              main_data_q <= in_data;
              main_ctrl_q <= in_ctrl;
              in_ready_q  <= 1'b1;
            end else begin
              // Only reachable with the skid buffer enabled.
              skid_data_q <= in_data;
              skid_ctrl_q <= in_ctrl;
              state_q     <= StSkid;
              in_ready_q  <= 1'b0;
            end
          end else begin
            in_ready_q <= 1'b1;
            if (out_ready) begin
              state_q <= StEmpty;
            end
          end
        end
        StSkid: begin
          if (out_ready) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
            state_q     <= StFull;
            in_ready_q  <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= StEmpty;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Head entry drives the outputs; control bits are zero in every bubble.
  always_comb begin
    out_data = main_data_q;
    out_ctrl = main_ctrl_q & {CTRL_W{out_valid}};
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: one skid-enabled and one single-register instance,
// each checked every cycle against a queue model of the handshake rules.
module tb_pipe_stage_skid_reg;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SKID_EN=1
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [3:0]  a_in_ctrl, a_out_ctrl;
  logic [1:0]  a_occ;
  // Instance B: SKID_EN=0
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [3:0]  b_in_ctrl, b_out_ctrl;
  logic [1:0]  b_occ;

  pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(4), .SKID_EN(1)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .occupancy(a_occ)
  );

  pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(4), .SKID_EN(0)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .occupancy(b_occ)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Model: each queue holds {ctrl, data} of accepted beats in acceptance order.
  logic [35:0] qa[$];
  logic [35:0] qb[$];
  int na, nb;
  logic a_acc, b_acc;

  always @(posedge clk) begin
    na = qa.size();
    nb = qb.size();
    if (!reset) begin
      qa.delete();
      qb.delete();
    end else begin
      // A accepts whenever fewer than two beats are held.
      a_acc = a_in_valid && (na < 2);
      if (a_flush) qa.delete();
      else begin
        if (na > 0 && a_out_ready) void'(qa.pop_front());
        if (a_acc) qa.push_back({a_in_ctrl, a_in_data});
      end
      // B accepts when empty or when its head leaves this cycle.
      b_acc = b_in_valid && (nb == 0 || b_out_ready);
      if (b_flush) qb.delete();
      else begin
        if (nb > 0 && b_out_ready) void'(qb.pop_front());
        if (b_acc) qb.push_back({b_in_ctrl, b_in_data});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("A.out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
      check("A.occupancy", 64'(a_occ), 64'(qa.size()));
      check("A.in_ready", 64'(a_in_ready), 64'(qa.size() < 2));
      check("A.out_ctrl", 64'(a_out_ctrl), (qa.size() > 0) ? 64'(qa[0][35:32]) : 64'd0);
      if (qa.size() > 0) check("A.out_data", 64'(a_out_data), 64'(qa[0][31:0]));
      check("B.out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
      check("B.occupancy", 64'(b_occ), 64'(qb.size()));
      check("B.in_ready", 64'(b_in_ready), 64'(qb.size() == 0 || b_out_ready));
      check("B.out_ctrl", 64'(b_out_ctrl), (qb.size() > 0) ? 64'(qb[0][35:32]) : 64'd0);
      if (qb.size() > 0) check("B.out_data", 64'(b_out_data), 64'(qb[0][31:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] va, ra, fa, vb, rb, fb;

  initial begin
    a_flush = 0; a_in_valid = 1; a_in_data = 32'hDEADBEEF; a_in_ctrl = 4'b0101; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = 0; b_in_ctrl = 0; b_out_ready = 0;
    repeat (3) tick();
    @(negedge clk);
    check("rst.held.out_valid", 64'(a_out_valid), 64'd0);
    check("rst.held.out_data", 64'(a_out_data), 64'd0);
    check("rst.held.in_ready", 64'(a_in_ready), 64'd1);
    tick();
    reset = 1;
    @(negedge clk);
    check("rst.rel.out_valid", 64'(a_out_valid), 64'd0);
    check("rst.rel.out_ctrl", 64'(a_out_ctrl), 64'd0);
    check("rst.rel.occupancy", 64'(a_occ), 64'd0);
    check("rst.rel.in_ready", 64'(a_in_ready), 64'd1);
    tick();
    a_in_valid = 0;
    @(negedge clk);
    check("rst.first.out_data", 64'(a_out_data), 64'hDEADBEEF);
    check("rst.first.out_valid", 64'(a_out_valid), 64'd1);
    a_out_ready = 1;
    tick();

    // Streaming at full rate.
    a_in_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      a_in_data = 32'(i);
      a_in_ctrl = 4'(i);
      tick();
      @(negedge clk);
      check("stream.out_data", 64'(a_out_data), 64'(i));
      check("stream.occupancy", 64'(a_occ), 64'd1);
      check("stream.in_ready", 64'(a_in_ready), 64'd1);
    end
    tick();
    a_in_valid = 0;
    tick();

    // Backpressure into the skid entry, then drain.
    a_in_valid = 1; a_in_data = 32'hA; a_in_ctrl = 4'b0011; a_out_ready = 1;
    tick();
    a_in_data = 32'hB; a_in_ctrl = 4'b1100; a_out_ready = 0;
    tick();
    a_in_valid = 0;
    @(negedge clk);
    check("bp.occupancy", 64'(a_occ), 64'd2);
    check("bp.in_ready", 64'(a_in_ready), 64'd0);
    check("bp.out_data", 64'(a_out_data), 64'hA);
    a_out_ready = 1;
    tick();
    @(negedge clk);
    check("bp.drain.out_data", 64'(a_out_data), 64'hB);
    check("bp.drain.in_ready", 64'(a_in_ready), 64'd1);
    tick();

    // Flush while in SKID with a beat offered.
    a_in_valid = 1; a_in_data = 32'h10; a_in_ctrl = 4'b1001; a_out_ready = 1;
    tick();
    a_in_data = 32'h11; a_out_ready = 0;
    tick();
    a_in_data = 32'hC; a_in_ctrl = 4'b1111; a_flush = 1;
    tick();
    a_flush = 0; a_in_valid = 0;
    @(negedge clk);
    check("flush.out_valid", 64'(a_out_valid), 64'd0);
    check("flush.out_ctrl", 64'(a_out_ctrl), 64'd0);
    check("flush.occupancy", 64'(a_occ), 64'd0);
    check("flush.in_ready", 64'(a_in_ready), 64'd1);
    a_out_ready = 1;
    tick();

    // Bubble masking with live control bits on the input.
    a_in_ctrl = 4'b1111; a_in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("bubble.out_ctrl", 64'(a_out_ctrl), 64'd0);
      check("bubble.out_valid", 64'(a_out_valid), 64'd0);
    end

    // Single-register variant: in_ready follows out_ready combinationally.
    b_in_valid = 1; b_in_data = 32'h5; b_in_ctrl = 4'b0110; b_out_ready = 0;
    tick();
    b_in_data = 32'h7; b_in_ctrl = 4'b1010;
    #1;
    check("noskid.stall.in_ready", 64'(b_in_ready), 64'd0);
    b_out_ready = 1;
    #1;
    check("noskid.go.in_ready", 64'(b_in_ready), 64'd1);
    tick();
    b_in_valid = 0;
    @(negedge clk);
    check("noskid.out_data", 64'(b_out_data), 64'h7);
    check("noskid.occupancy", 64'(b_occ), 64'd1);
    tick();

    // Mixed directed traffic on both instances, including a flush.
    va = 16'b1011_1110_0111_0101; ra = 16'b0110_0011_1101_1001; fa = 16'b0000_0100_0000_0000;
    vb = 16'b1101_0111_1011_1110; rb = 16'b1010_1100_0111_0011; fb = 16'b0010_0000_0000_0000;
    for (int i = 0; i < 16; i++) begin
      a_in_valid = va[i]; a_out_ready = ra[i]; a_flush = fa[i];
      a_in_data = 32'h100 + 32'(i); a_in_ctrl = 4'(i) ^ 4'hA;
      b_in_valid = vb[i]; b_out_ready = rb[i]; b_flush = fb[i];
      b_in_data = 32'h200 + 32'(i); b_in_ctrl = 4'(i) ^ 4'h5;
      tick();
    end
    a_in_valid = 0; a_flush = 0; a_out_ready = 1;
    b_in_valid = 0; b_flush = 0; b_out_ready = 1;
    repeat (3) tick();

    // Reset asserted with both entries held drops everything at once.
    a_in_valid = 1; a_in_data = 32'h20; a_out_ready = 0;
    tick();
    a_in_data = 32'h21;
    tick();
    a_in_valid = 0;
    reset = 0;
    #1;
    check("rst.mid.out_valid", 64'(a_out_valid), 64'd0);
    check("rst.mid.occupancy", 64'(a_occ), 64'd0);
    check("rst.mid.in_ready", 64'(a_in_ready), 64'd1);
    check("rst.mid.out_data", 64'(a_out_data), 64'd0);
    tick();
    reset = 1;
    a_out_ready = 1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
